// File: rtl/multi_buffer_slv.sv
// AXI4 write-only slave: each write burst is captured into one of NUM_BUF_g
// buffers, and committed buffers are drained in arrival order onto a
// valid/ready stream.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for AW; awready when at least one buffer is free
// DATA  | accepting W beats into the claimed buffer (wr_ptr)
// RESP  | holding B response until bready; buffer already committed
module multi_buffer_slv #(
  parameter int AXI_DW_g    = 64,
  parameter int AXI_AW_g    = 32,
  parameter int NUM_BUF_g   = 4,
  parameter int BUF_DEPTH_g = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  output logic                          s_axi_awready_o,
  input  logic                          s_axi_awvalid_i,
  input  logic [AXI_AW_g-1:0]           s_axi_awaddr_i,
  input  logic [7:0]                    s_axi_awlen_i,
  input  logic [2:0]                    s_axi_awsize_i,
  input  logic [1:0]                    s_axi_awburst_i,
  output logic                          s_axi_wready_o,
  input  logic                          s_axi_wvalid_i,
  input  logic [AXI_DW_g-1:0]           s_axi_wdata_i,
  input  logic [AXI_DW_g/8-1:0]         s_axi_wstrb_i,
  input  logic                          s_axi_wlast_i,
  input  logic                          s_axi_bready_i,
  output logic                          s_axi_bvalid_o,
  output logic [1:0]                    s_axi_bresp_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [AXI_DW_g-1:0]           m_data_o,
  output logic [AXI_DW_g/8-1:0]         m_strb_o,
  output logic                          m_last_o,
  output logic [$clog2(NUM_BUF_g+1)-1:0] free_cnt_o
);

  localparam int SW = AXI_DW_g / 8;
  localparam int PW = (NUM_BUF_g > 1) ? $clog2(NUM_BUF_g) : 1;
  localparam int IW = (BUF_DEPTH_g > 1) ? $clog2(BUF_DEPTH_g) : 1;
  localparam int LW = $clog2(BUF_DEPTH_g + 1);
  localparam int CW = $clog2(NUM_BUF_g + 1);
  localparam logic [8:0]    DEPTH_C    = 9'(BUF_DEPTH_g);
  localparam logic [PW-1:0] LAST_PTR_C = PW'(NUM_BUF_g - 1);
  localparam logic [CW-1:0] NUM_BUF_C  = CW'(NUM_BUF_g);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_state_e;

  wr_state_e             state_q, state_d;
  logic [7:0]            len_q, len_d;
  logic [8:0]            cnt_q, cnt_d;     // saturating beat count of current burst
  logic                  err_q, err_d;
  logic                  awready_q, awready_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [NUM_BUF_g-1:0]  commit_q, commit_d;
  logic [LW-1:0]         rd_idx_q, rd_idx_d;
  logic                  m_valid_q, m_valid_d;
  logic [CW-1:0]         free_q, free_d;

  logic [AXI_DW_g-1:0]   data_mem_q [NUM_BUF_g][BUF_DEPTH_g];
  logic [SW-1:0]         strb_mem_q [NUM_BUF_g][BUF_DEPTH_g];
  logic [LW-1:0]         blen_q     [NUM_BUF_g];

  logic aw_hs, w_hs, b_hs, m_hs, rel, w_store;
  logic unused_inputs;

  assign unused_inputs = ^{s_axi_awaddr_i, s_axi_awsize_i};

  assign aw_hs   = s_axi_awvalid_i && awready_q;
  assign w_hs    = s_axi_wvalid_i && (state_q == DATA);
  assign b_hs    = s_axi_bready_i && (state_q == RESP);
  assign m_hs    = m_valid_q && m_ready_i;
  assign rel     = m_hs && m_last_o;
  assign w_store = w_hs && (cnt_q < DEPTH_C);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR_C) ? '0 : p + PW'(1);
  endfunction

  // Next-state for the write FSM, buffer bookkeeping and the drain side.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    commit_d  = commit_q;
    rd_idx_d  = rd_idx_q;
    free_d    = free_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          len_d   = s_axi_awlen_i;
          cnt_d   = '0;
          err_d   = (s_axi_awburst_i == 2'b10) || (({1'b0, s_axi_awlen_i} + 9'd1) > DEPTH_C);
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          if (cnt_q != '1) cnt_d = cnt_q + 9'd1;
          if (cnt_q >= DEPTH_C) err_d = 1'b1;
          // wlast must coincide with beat len+1; either mismatch flags an error
          if (s_axi_wlast_i != (cnt_q == {1'b0, len_q})) err_d = 1'b1;
          if (s_axi_wlast_i) begin
            state_d            = RESP;
            commit_d[wr_ptr_q] = 1'b1;
            wr_ptr_d           = ptr_inc(wr_ptr_q);
          end
        end
      end
      RESP: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      commit_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = ptr_inc(rd_ptr_q);
      rd_idx_d           = '0;
    end else if (m_hs) begin
      rd_idx_d = rd_idx_q + LW'(1);
    end

    // Dropping valid for one cycle after a release gives the bubble before
    // the next buffer is presented.
    m_valid_d = m_valid_q ? !rel : commit_q[rd_ptr_q];

    if (aw_hs && !rel)      free_d = free_q - CW'(1);
    else if (!aw_hs && rel) free_d = free_q + CW'(1);

    awready_d = (state_d == IDLE) && (free_d != '0);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      commit_q  <= '0;
      rd_idx_q  <= '0;
      m_valid_q <= 1'b0;
      free_q    <= NUM_BUF_C;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      awready_q <= awready_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      commit_q  <= commit_d;
      rd_idx_q  <= rd_idx_d;
      m_valid_q <= m_valid_d;
      free_q    <= free_d;
    end
  end

  // Beat storage and per-buffer length; contents only matter once committed.
  always_ff @(posedge clk_i) begin
    if (w_store) begin
      data_mem_q[wr_ptr_q][cnt_q[IW-1:0]] <= s_axi_wdata_i;
      strb_mem_q[wr_ptr_q][cnt_q[IW-1:0]] <= s_axi_wstrb_i;
    end
    if (w_hs && s_axi_wlast_i) begin
      blen_q[wr_ptr_q] <= (cnt_q < DEPTH_C) ? LW'(cnt_q + 9'd1) : LW'(BUF_DEPTH_g);
    end
  end

  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = (state_q == DATA);
  assign s_axi_bvalid_o  = (state_q == RESP);
  assign s_axi_bresp_o   = ((state_q == RESP) && err_q) ? 2'b10 : 2'b00;
  assign m_valid_o       = m_valid_q;
  assign m_last_o        = m_valid_q && (rd_idx_q == (blen_q[rd_ptr_q] - LW'(1)));
  assign m_data_o        = m_valid_q ? data_mem_q[rd_ptr_q][rd_idx_q[IW-1:0]] : '0;
  assign m_strb_o        = m_valid_q ? strb_mem_q[rd_ptr_q][rd_idx_q[IW-1:0]] : '0;
  assign free_cnt_o      = free_q;

endmodule
